score_digit_driver: RTL and testbench
=====================================

Name: score_digit_driver

Overview:
- Front end for the digit-glyph pixel lookup block; drives its ADDR, display-digit and place-select inputs.
- Converts a binary game score to four BCD digits with an iterative double-dabble engine.
- Maps the current VGA pixel (x, y) to a place select and a glyph-relative ROM index, so the score renders as four 30x30 glyphs, thousands leftmost.

Parameters:
- ORIGIN_X, 10'd560, x of left edge of the thousands glyph
- ORIGIN_Y, 10'd20, y of top edge of all glyphs
- GLYPH_W, 30, glyph width in pixels; one ROM image is GLYPH_W*GLYPH_H = 900 entries
- GLYPH_H, 30, glyph height in pixels
- SCORE_W, 14, binary score width

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- score  in  SCORE_W  binary score to display
- score_valid  in  1  one-cycle strobe: request conversion of score
- busy  out  1  conversion in progress
- x  in  10  current VGA pixel column
- y  in  10  current VGA pixel row
- ADDR  out  15  glyph-relative pixel index, 0..899
- display_ones, display_tens, display_hundreds, display_thousands  out  4 each  committed BCD digits
- ones, tens, hundreds, thousands  out  1 each  one-hot place select; all 0 outside the score region
- in_region  out  1  pixel lies inside the 4-glyph score box

Behaviour:
- Reset: all outputs 0, FSM in IDLE, pending flag cleared, shift registers cleared.
- Saturation: score > 9999 is converted as 9999 when captured.
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: on score_valid, capture the saturated score, clear the 16-bit BCD accumulator, load iteration count SCORE_W, go to SHIFT. busy=1 from the next cycle.
  - SHIFT: one iteration per cycle.
    - Each BCD nibble >= 5 gets +3.
    - Then shift {bcd, bin} left by 1.
    - Decrement the count; after SCORE_W iterations, go to COMMIT.
  - COMMIT: load display_* from the accumulator, all four digits in the same edge.
    - busy=0 from the next cycle.
    - If the pending flag is set, clear it and go to SHIFT with the pending value; otherwise go to IDLE.
- Latency: score_valid at edge N gives display_* updated at edge N+SCORE_W+2 (16 cycles at default).
- score_valid while busy or in COMMIT: the value is saved in the pending register; a later strobe overwrites the earlier pending value. Only the most recent value is converted next. display_* never shows a partial result.
- Pixel mapping (registered, 1-cycle latency, computed every cycle independent of the FSM):
  - col = x - ORIGIN_X, row = y - ORIGIN_Y; the subtraction must not wrap.
  - in_region = (x >= ORIGIN_X) && (x < ORIGIN_X + 4*GLYPH_W) && (y >= ORIGIN_Y) && (y < ORIGIN_Y + GLYPH_H).
  - Place select by constant compares:
    - col 0..29: thousands
    - col 30..59: hundreds
    - col 60..89: tens
    - col 90..119: ones
  - k = place index (thousands=0 .. ones=3); lc = col - k*GLYPH_W.
  - ADDR = row*GLYPH_W + lc. Width: 15 bits; maximum value 899.
  - Outside region: ADDR = 0, all place selects 0, in_region = 0.
- Exactly one place select is high when in_region=1.
- Reset mid-conversion: abort immediately. Digits return to 0, pending is discarded.

Decomposition:
- Shared package (score_pkg): GLYPH_W, GLYPH_H, GLYPH_PIXELS=900, MAX_SCORE=9999, FSM state encoding.
- One sub-module: bin2bcd_iter, containing the double-dabble FSM, pending register and commit.
- The top level holds the pixel-mapping pipeline stage and instantiates bin2bcd_iter.

Test Plan:
- Reset then score=1234, strobe: busy high for 15 cycles, then display_thousands/hundreds/tens/ones = 1/2/3/4 at exactly cycle 16; all four change on the same edge.
- score=12000: converts to 9,9,9,9. score=0: converts to 0,0,0,0.
- Strobe 50, then strobe 777 and 305 while busy: display shows 0050, then 0305. 777 is never displayed.
- x=ORIGIN_X+31, y=ORIGIN_Y+2: next cycle hundreds=1, others 0, ADDR=61, in_region=1.
- x=ORIGIN_X+119, y=ORIGIN_Y+29 gives ones=1, ADDR=899. x=ORIGIN_X+120 gives in_region=0, ADDR=0. x=ORIGIN_X-1 gives in_region=0, with no wrap to a valid place.
- Assert reset during cycle 8 of a conversion of 4321: outputs 0 immediately, busy=0; the next strobe of 42 converts cleanly to 0042.

Source files
------------

// File: rtl/score_pkg.sv
// Shared constants, FSM encoding and the double-dabble digit adjust used by the
// score digit driver and its BCD conversion engine.
package score_pkg;

    localparam int GLYPH_W      = 30;
    localparam int GLYPH_H      = 30;
    localparam int GLYPH_PIXELS = GLYPH_W * GLYPH_H;
    localparam int MAX_SCORE    = 9999;
    localparam int BCD_DIGITS   = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } bcd_state_t;

    // A BCD nibble that will overflow past 9 after the next doubling gets +3 first.
    function automatic logic [3:0] dabble_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/score_digit_driver_bin2bcd_iter.sv
// Iterative double-dabble converter: one shift per cycle, a single-entry pending
// slot for strobes that arrive mid-conversion, and an atomic commit of all digits.
module bin2bcd_iter
    import score_pkg::*;
#(
    parameter int SCORE_W = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SCORE_W-1:0] score,
    input  logic               score_valid,
    output logic               busy,
    output logic [15:0]        digits
);

    localparam int CNT_W = $clog2(SCORE_W + 1);

    bcd_state_t         state_reg, state_next;
    logic [SCORE_W-1:0] bin_reg, bin_next;
    logic [15:0]        bcd_reg, bcd_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               pending_reg, pending_next;
    logic [SCORE_W-1:0] pend_val_reg, pend_val_next;
    logic [15:0]        digits_reg, digits_next;
    logic [SCORE_W-1:0] score_sat;
    logic [15:0]        bcd_adj;

    assign score_sat = (32'(score) > MAX_SCORE) ? SCORE_W'(MAX_SCORE) : score;

    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
        assign bcd_adj[gi*4 +: 4] = dabble_adjust(bcd_reg[gi*4 +: 4]);
    end

    always_comb begin
        state_next    = state_reg;
        bin_next      = bin_reg;
        bcd_next      = bcd_reg;
        count_next    = count_reg;
        pending_next  = pending_reg;
        pend_val_next = pend_val_reg;
        digits_next   = digits_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (score_valid) begin
                    bin_next   = score_sat;
                    bcd_next   = '0;
                    count_next = CNT_W'(SCORE_W);
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (score_valid) begin
                    pending_next  = 1'b1;
                    pend_val_next = score_sat;
                end
                if (count_reg != '0) begin
                    bcd_next   = {bcd_adj[14:0], bin_reg[SCORE_W-1]};
                    bin_next   = bin_reg << 1;
                    count_next = count_reg - CNT_W'(1);
                end else begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                digits_next = bcd_reg;
                // A strobe landing on the commit cycle is newer than anything pending.
                if (score_valid || pending_reg) begin
                    bin_next     = score_valid ? score_sat : pend_val_reg;
                    bcd_next     = '0;
                    count_next   = CNT_W'(SCORE_W);
                    pending_next = 1'b0;
                    state_next   = ST_SHIFT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            bin_reg      <= '0;
            bcd_reg      <= '0;
            count_reg    <= '0;
            pending_reg  <= 1'b0;
            pend_val_reg <= '0;
            digits_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            bin_reg      <= bin_next;
            bcd_reg      <= bcd_next;
            count_reg    <= count_next;
            pending_reg  <= pending_next;
            pend_val_reg <= pend_val_next;
            digits_reg   <= digits_next;
        end
    end

    assign busy   = (state_reg != ST_IDLE);
    assign digits = digits_reg;

endmodule

// File: rtl/score_digit_driver.sv
// Score overlay front end: BCD conversion of the game score plus a registered
// pixel-to-glyph mapping that feeds the digit glyph ROM lookup.
module score_digit_driver
    import score_pkg::*;
#(
    parameter logic [9:0] ORIGIN_X = 10'd560,
    parameter logic [9:0] ORIGIN_Y = 10'd20,
    parameter int         GLYPH_W  = score_pkg::GLYPH_W,
    parameter int         GLYPH_H  = score_pkg::GLYPH_H,
    parameter int         SCORE_W  = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SCORE_W-1:0] score,
    input  logic               score_valid,
    output logic               busy,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    output logic [14:0]        ADDR,
    output logic [3:0]         display_ones,
    output logic [3:0]         display_tens,
    output logic [3:0]         display_hundreds,
    output logic [3:0]         display_thousands,
    output logic               ones,
    output logic               tens,
    output logic               hundreds,
    output logic               thousands,
    output logic               in_region
);

    localparam logic [10:0] X_LO = {1'b0, ORIGIN_X};
    localparam logic [10:0] X_HI = X_LO + 11'(4 * GLYPH_W);
    localparam logic [10:0] Y_LO = {1'b0, ORIGIN_Y};
    localparam logic [10:0] Y_HI = Y_LO + 11'(GLYPH_H);

    logic [15:0] digits;
    logic        hit;
    logic [9:0]  col;
    logic [9:0]  row;
    logic [9:0]  lc;
    logic [3:0]  place;
    logic [14:0] addr_next;
    logic [14:0] addr_reg;
    logic [3:0]  place_reg;
    logic        in_region_reg;

    bin2bcd_iter #(
        .SCORE_W (SCORE_W)
    ) u_bin2bcd (
        .clk         (clk),
        .reset       (reset),
        .score       (score),
        .score_valid (score_valid),
        .busy        (busy),
        .digits      (digits)
    );

    // Compares are done one bit wider so the right/bottom edges cannot overflow.
    assign hit = ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI) &&
                 ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);
    assign col = hit ? (x - ORIGIN_X) : '0;
    assign row = hit ? (y - ORIGIN_Y) : '0;

    // place[0] is the leftmost (thousands) glyph.
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_place
        if (gi == 0) begin : g_first
            assign place[gi] = hit && (col < 10'(GLYPH_W));
        end else begin : g_rest
            assign place[gi] = hit && (col >= 10'(gi * GLYPH_W)) &&
                               (col < 10'((gi + 1) * GLYPH_W));
        end
    end

    always_comb begin
        lc = '0;
        for (int k = 0; k < BCD_DIGITS; k++) begin
            if (place[k]) begin
                lc = col - 10'(k * GLYPH_W);
            end
        end
    end

    assign addr_next = hit ? (15'(row) * 15'(GLYPH_W) + 15'(lc)) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_reg      <= '0;
            place_reg     <= '0;
            in_region_reg <= 1'b0;
        end else begin
            addr_reg      <= addr_next;
            place_reg     <= place;
            in_region_reg <= hit;
        end
    end

    assign ADDR              = addr_reg;
    assign thousands         = place_reg[0];
    assign hundreds          = place_reg[1];
    assign tens              = place_reg[2];
    assign ones              = place_reg[3];
    assign in_region         = in_region_reg;
    assign display_thousands = digits[15:12];
    assign display_hundreds  = digits[11:8];
    assign display_tens      = digits[7:4];
    assign display_ones      = digits[3:0];

endmodule

// File: tb/tb_score_digit_driver.sv
// Self-checking bench for score_digit_driver: directed and random conversions and
// pixel positions compared against an arithmetic reference model.
module tb_score_digit_driver;

    localparam int OX = 560;
    localparam int OY = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] score;
    logic        score_valid;
    logic        busy;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [14:0] ADDR;
    logic [3:0]  display_ones, display_tens, display_hundreds, display_thousands;
    logic        ones, tens, hundreds, thousands, in_region;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    score_digit_driver dut (
        .clk               (clk),
        .reset             (reset),
        .score             (score),
        .score_valid       (score_valid),
        .busy              (busy),
        .x                 (x),
        .y                 (y),
        .ADDR              (ADDR),
        .display_ones      (display_ones),
        .display_tens      (display_tens),
        .display_hundreds  (display_hundreds),
        .display_thousands (display_thousands),
        .ones              (ones),
        .tens              (tens),
        .hundreds          (hundreds),
        .thousands         (thousands),
        .in_region         (in_region)
    );

    wire [15:0] disp  = {display_thousands, display_hundreds, display_tens, display_ones};
    wire [3:0]  place = {thousands, hundreds, tens, ones};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Decimal digits of the saturated score, thousands in the top nibble.
    function automatic logic [15:0] to_bcd(input int unsigned v);
        int unsigned s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    // {in_region, thousands, hundreds, tens, ones, ADDR}
    function automatic logic [19:0] pix_model(input int xx, input int yy);
        logic [19:0] r;
        int col, row, k;
        r = '0;
        if (xx >= OX && xx < OX + 120 && yy >= OY && yy < OY + 30) begin
            col = xx - OX;
            row = yy - OY;
            k = col / 30;
            r[19] = 1'b1;
            r[18 - k] = 1'b1;
            r[14:0] = 15'(row * 30 + col % 30);
        end
        return r;
    endfunction

    task automatic convert(input logic [13:0] val);
        logic [15:0] old_d, exp_d;
        old_d = disp;
        exp_d = to_bcd(int'(val));
        score = val;
        score_valid = 1'b1;
        @(negedge clk);
        score_valid = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            check($sformatf("busy_%0d_c%0d", val, i), 32'(busy), 32'd1);
            check($sformatf("hold_%0d_c%0d", val, i), 32'(disp), 32'(old_d));
        end
        @(negedge clk);
        check($sformatf("busy_done_%0d", val), 32'(busy), 32'd0);
        check($sformatf("digits_%0d", val), 32'(disp), 32'(exp_d));
        $display("convert score=%0d -> display=%h (expected %h)", val, disp, exp_d);
    endtask

    task automatic pixel(input int xx, input int yy);
        logic [19:0] m;
        m = pix_model(xx, yy);
        x = 10'(xx);
        y = 10'(yy);
        @(negedge clk);
        check($sformatf("in_region_%0d_%0d", xx, yy), 32'(in_region), 32'(m[19]));
        check($sformatf("place_%0d_%0d", xx, yy), 32'(place), 32'(m[18:15]));
        check($sformatf("addr_%0d_%0d", xx, yy), 32'(ADDR), 32'(m[14:0]));
        $display("pixel x=%0d y=%0d -> in_region=%0b place=%b ADDR=%0d", xx, yy, in_region, place, ADDR);
    endtask

    initial begin
        bit seen777;
        reset = 1'b1;
        score = '0;
        score_valid = 1'b0;
        x = '0;
        y = '0;
        #12;
        check("reset_disp", 32'(disp), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_place", 32'(place), 32'd0);
        check("reset_addr", 32'(ADDR), 32'd0);
        check("reset_inreg", 32'(in_region), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        convert(14'd1234);
        convert(14'd12000);
        convert(14'd0);
        convert(14'd9999);
        convert(14'd16383);
        for (int n = 0; n < 6; n++) begin
            convert(14'($urandom_range(0, 16383)));
        end

        // Strobes during a conversion: only the latest one is converted next.
        seen777 = 1'b0;
        score = 14'd50;
        score_valid = 1'b1;
        @(negedge clk);
        score_valid = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (disp == 16'h0777) seen777 = 1'b1;
            if (i == 16) check("pend_first_0050", 32'(disp), 32'h0050);
            if (i == 31) check("pend_hold_0050", 32'(disp), 32'h0050);
            if (i == 32) check("pend_second_0305", 32'(disp), 32'h0305);
            score_valid = (i == 3) || (i == 8);
            score = (i == 3) ? 14'd777 : 14'd305;
        end
        score_valid = 1'b0;
        check("pend_never_777", 32'(seen777), 32'd0);
        check("pend_idle", 32'(busy), 32'd0);
        $display("pending sequence 50,777,305 -> display=%h", disp);

        pixel(OX + 31, OY + 2);
        pixel(OX + 119, OY + 29);
        pixel(OX + 120, OY + 29);
        pixel(OX - 1, OY + 2);
        pixel(OX, OY);
        pixel(OX + 60, OY + 30);
        pixel(OX + 89, OY - 1);
        pixel(0, 0);
        for (int n = 0; n < 30; n++) begin
            pixel(int'($urandom_range(540, 700)), int'($urandom_range(0, 60)));
        end

        // Asynchronous reset in the middle of a conversion.
        x = 10'(OX + 31);
        y = 10'(OY + 2);
        score = 14'd4321;
        score_valid = 1'b1;
        @(negedge clk);
        score_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        check("pre_reset_addr", 32'(ADDR), 32'd61);
        #2 reset = 1'b1;
        #1;
        check("mid_reset_disp", 32'(disp), 32'd0);
        check("mid_reset_busy", 32'(busy), 32'd0);
        check("mid_reset_addr", 32'(ADDR), 32'd0);
        check("mid_reset_place", 32'(place), 32'd0);
        $display("reset mid-conversion -> display=%h busy=%0b", disp, busy);
        @(negedge clk);
        reset = 1'b0;
        x = '0;
        y = '0;
        @(negedge clk);
        check("post_reset_busy", 32'(busy), 32'd0);
        check("post_reset_disp", 32'(disp), 32'd0);
        convert(14'd42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
